// File: rtl/adxl362_pkg.sv
// Shared constants, state encodings and frame byte table for the ADXL362 X-axis reader.
package adxl362_pkg;

    localparam logic [7:0] OP_WRITE      = 8'h0A;
    localparam logic [7:0] OP_READ       = 8'h0B;
    localparam logic [7:0] REG_POWER_CTL = 8'h2D;
    localparam logic [7:0] REG_XDATA_L   = 8'h0E;
    localparam logic [7:0] MEAS_MODE     = 8'h02;

    typedef enum logic [2:0] {
        ST_STARTUP,
        ST_INIT_XFER,
        ST_INIT_GAP,
        ST_WAIT_SAMPLE,
        ST_READ_XFER,
        ST_UPDATE
    } state_t;

    // Sub-phases of a CS_n frame: shifting bytes, CS_n hold after last SCLK fall, CS_n high gap.
    typedef enum logic [1:0] {
        PH_BYTES,
        PH_TAIL,
        PH_GAP
    } phase_t;

    // Captured X sample; XDATA_H[7:4] carries no information and is not stored.
    typedef struct packed {
        logic [3:0] hi;
        logic [7:0] lo;
    } xdata_t;

    function automatic logic [7:0] frame_byte(input logic is_read, input logic [1:0] idx);
        logic [7:0] b;
        b = 8'h00;
        if (is_read) begin
            case (idx)
                2'd0:    b = OP_READ;
                2'd1:    b = REG_XDATA_L;
                default: b = 8'h00;
            endcase
        end else begin
            case (idx)
                2'd0:    b = OP_WRITE;
                2'd1:    b = REG_POWER_CTL;
                2'd2:    b = MEAS_MODE;
                default: b = 8'h00;
            endcase
        end
        return b;
    endfunction

endpackage

// File: rtl/adxl362_x_reader_spi.sv
// SPI mode-0 byte engine: 8 SCLK periods per byte, MOSI shifted on falls, MISO sampled on rises.
module spi_byte_shifter #(
    parameter int unsigned CLK_DIV = 50
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] tx_byte,
    input  logic       miso,
    output logic       sclk,
    output logic       mosi,
    output logic       done,
    output logic [7:0] rx_byte
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic             active;
    logic [DIV_W-1:0] div_cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       tx_sr;
    logic [7:0]       rx_sr;
    logic             half_end;

    assign half_end = active && (div_cnt == DIV_LAST);
    // Combinational so the caller can reload on the same edge and keep SCLK gap-free.
    assign done     = half_end && sclk && (bit_cnt == 3'd7);
    assign rx_byte  = rx_sr;
    assign mosi     = tx_sr[7];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            active  <= 1'b0;
            sclk    <= 1'b0;
            div_cnt <= '0;
            bit_cnt <= '0;
            tx_sr   <= '0;
            rx_sr   <= '0;
        end else if (start) begin
            active  <= 1'b1;
            sclk    <= 1'b0;
            div_cnt <= '0;
            bit_cnt <= '0;
            tx_sr   <= tx_byte;
        end else if (active) begin
            if (half_end) begin
                div_cnt <= '0;
                if (!sclk) begin
                    sclk  <= 1'b1;
                    rx_sr <= {rx_sr[6:0], miso};
                end else begin
                    sclk    <= 1'b0;
                    tx_sr   <= {tx_sr[6:0], 1'b0};
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) active <= 1'b0;
                end
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
        end
    end

endmodule

// File: rtl/adxl362_x_reader.sv
// Brings the ADXL362 into measurement mode, then reads XDATA_L/H every SAMPLE_PERIOD clocks
// and presents the 12-bit sample sign-extended to 15 bits.
module adxl362_x_reader #(
    parameter int unsigned CLK_DIV       = 50,
    parameter int unsigned SAMPLE_PERIOD = 10_000_000,
    parameter int unsigned STARTUP_WAIT  = 1_000_000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        SCLK,
    output logic        MOSI,
    input  logic        MISO,
    output logic        CS_n,
    output logic [14:0] value_X,
    output logic        data_valid
);

    import adxl362_pkg::*;

    localparam logic [31:0] DIV_LAST    = 32'(CLK_DIV - 1);
    localparam logic [31:0] GAP_LAST    = 32'(2 * CLK_DIV - 1);
    localparam logic [31:0] SW_LAST     = 32'(STARTUP_WAIT - 1);
    localparam logic [31:0] PERIOD_LAST = 32'(SAMPLE_PERIOD - 1);

    state_t      state, state_d;
    phase_t      phase, phase_d;
    logic [31:0] cnt, cnt_d;
    logic [31:0] timer;
    logic        pending, pend_d;
    logic [1:0]  byte_idx, byte_idx_d;
    logic        cs_n, cs_n_d;
    xdata_t      xd, xd_d;
    logic [14:0] value_d;
    logic        dv_d;

    logic        start;
    logic [7:0]  tx_byte;
    logic        sh_done;
    logic [7:0]  rx_byte;
    logic        sh_sclk;
    logic        sh_mosi;

    logic        timer_run;
    logic        wrap;
    logic        is_read;
    logic [1:0]  last_idx;

    spi_byte_shifter #(.CLK_DIV(CLK_DIV)) u_shifter (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .tx_byte (tx_byte),
        .miso    (MISO),
        .sclk    (sh_sclk),
        .mosi    (sh_mosi),
        .done    (sh_done),
        .rx_byte (rx_byte)
    );

    assign SCLK = sh_sclk;
    assign MOSI = sh_mosi & ~cs_n;
    assign CS_n = cs_n;

    // Sample timer keeps running through the read frame so read starts stay period-aligned.
    assign timer_run = (state == ST_WAIT_SAMPLE) || (state == ST_READ_XFER) || (state == ST_UPDATE);
    assign wrap      = timer_run && (timer == PERIOD_LAST);
    assign is_read   = (state == ST_READ_XFER);
    assign last_idx  = is_read ? 2'd3 : 2'd2;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)         timer <= '0;
        else if (!timer_run) timer <= '0;
        else if (wrap)      timer <= '0;
        else                timer <= timer + 32'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_STARTUP;
            phase      <= PH_BYTES;
            cnt        <= '0;
            pending    <= 1'b0;
            byte_idx   <= '0;
            cs_n       <= 1'b1;
            xd         <= '0;
            value_X    <= '0;
            data_valid <= 1'b0;
        end else begin
            state      <= state_d;
            phase      <= phase_d;
            cnt        <= cnt_d;
            pending    <= pend_d;
            byte_idx   <= byte_idx_d;
            cs_n       <= cs_n_d;
            xd         <= xd_d;
            value_X    <= value_d;
            data_valid <= dv_d;
        end
    end

    always_comb begin
        state_d    = state;
        phase_d    = phase;
        cnt_d      = cnt;
        pend_d     = pending | wrap;
        byte_idx_d = byte_idx;
        cs_n_d     = cs_n;
        xd_d       = xd;
        value_d    = value_X;
        dv_d       = 1'b0;
        start      = 1'b0;
        tx_byte    = 8'h00;

        case (state)
            ST_STARTUP: begin
                if (cnt == SW_LAST) begin
                    cnt_d      = '0;
                    cs_n_d     = 1'b0;
                    start      = 1'b1;
                    tx_byte    = frame_byte(1'b0, 2'd0);
                    byte_idx_d = 2'd0;
                    phase_d    = PH_BYTES;
                    state_d    = ST_INIT_XFER;
                end else begin
                    cnt_d = cnt + 32'd1;
                end
            end

            ST_INIT_XFER, ST_READ_XFER: begin
                case (phase)
                    PH_BYTES: begin
                        if (sh_done) begin
                            if (is_read && byte_idx == 2'd2) xd_d.lo = rx_byte;
                            if (is_read && byte_idx == 2'd3) xd_d.hi = rx_byte[3:0];
                            if (byte_idx == last_idx) begin
                                phase_d = PH_TAIL;
                                cnt_d   = '0;
                            end else begin
                                byte_idx_d = byte_idx + 2'd1;
                                start      = 1'b1;
                                tx_byte    = frame_byte(is_read, byte_idx + 2'd1);
                            end
                        end
                    end
                    PH_TAIL: begin
                        if (cnt == DIV_LAST) begin
                            cs_n_d = 1'b1;
                            cnt_d  = '0;
                            if (is_read) phase_d = PH_GAP;
                            else         state_d = ST_INIT_GAP;
                        end else begin
                            cnt_d = cnt + 32'd1;
                        end
                    end
                    default: begin
                        // Enforced CS_n high time, so back-to-back reads still get a full gap.
                        if (cnt == GAP_LAST) begin
                            cnt_d   = '0;
                            state_d = ST_UPDATE;
                        end else begin
                            cnt_d = cnt + 32'd1;
                        end
                    end
                endcase
            end

            ST_INIT_GAP: begin
                if (cnt == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_WAIT_SAMPLE;
                end else begin
                    cnt_d = cnt + 32'd1;
                end
            end

            ST_WAIT_SAMPLE: begin
                if (wrap || pending) begin
                    pend_d     = 1'b0;
                    cs_n_d     = 1'b0;
                    start      = 1'b1;
                    tx_byte    = frame_byte(1'b1, 2'd0);
                    byte_idx_d = 2'd0;
                    phase_d    = PH_BYTES;
                    state_d    = ST_READ_XFER;
                end
            end

            ST_UPDATE: begin
                value_d = {{3{xd.hi[3]}}, xd.hi, xd.lo};
                dv_d    = 1'b1;
                state_d = ST_WAIT_SAMPLE;
            end

            default: state_d = ST_STARTUP;
        endcase
    end

endmodule

// File: tb/tb_adxl362_x_reader.sv
// Bench for adxl362_x_reader: SPI slave model with scoreboarded X samples, plus a second
// instance with a period shorter than a frame to exercise back-to-back reads.
module tb_adxl362_x_reader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        miso = 1'b0;
    logic        miso_f;
    logic        SCLK, MOSI, CS_n, data_valid;
    logic [14:0] value_X;
    logic        sclk_f, mosi_f, cs_f, dv_f;
    logic [14:0] value_f;

    always #5 clk = ~clk;

    adxl362_x_reader #(.CLK_DIV(4), .SAMPLE_PERIOD(2000), .STARTUP_WAIT(100)) u_dut (
        .clk(clk), .reset(rst_n), .SCLK(SCLK), .MOSI(MOSI), .MISO(miso),
        .CS_n(CS_n), .value_X(value_X), .data_valid(data_valid)
    );

    adxl362_x_reader #(.CLK_DIV(4), .SAMPLE_PERIOD(50), .STARTUP_WAIT(100)) u_fast (
        .clk(clk), .reset(rst_n), .SCLK(sclk_f), .MOSI(mosi_f), .MISO(miso_f),
        .CS_n(cs_f), .value_X(value_f), .data_valid(dv_f)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic chk_ok(input string name, input bit ok, input int got);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s got=%0d", name, got);
        end
    endtask

    // Expected sample from the datasheet rule: 12-bit signed value, shown as 15-bit two's complement.
    function automatic logic [14:0] expect_x(input logic [7:0] xl, input logic [7:0] xh);
        int v;
        v = ((int'(xh) & 15) << 8) | int'(xl);
        if (v >= 2048) v = v - 4096;
        return v[14:0];
    endfunction

    logic [7:0]  r_xl[16];
    logic [7:0]  r_xh[16];
    int          r_idx = 0;

    logic [14:0] exp_q[$];
    logic [14:0] held;
    int          dv_cnt = 0, stable_bad = 0, proto_bad = 0;
    bit          cs_p, sclk_p, mosi_p, in_frame, is_rd, have_rd_fall, spacing_bad;
    int          frame_no, rises, bitk;
    int          fall_cyc, rise_cyc, first_rise, last_rise, last_fall, last_rd_fall;
    logic [31:0] mosi_sr, miso_word;

    // SPI slave + scoreboard monitor for the main instance.
    always @(negedge clk) begin
        if (!rst_n) begin
            cs_p = 1'b1; sclk_p = 1'b0; mosi_p = 1'b0; in_frame = 1'b0;
            frame_no = 0; have_rd_fall = 1'b0; held = '0; miso = 1'b0;
            exp_q.delete();
        end else begin
            if (CS_n && (SCLK || MOSI)) proto_bad++;
            if (SCLK && sclk_p && (MOSI != mosi_p)) proto_bad++;

            if (data_valid) begin
                dv_cnt++;
                if (exp_q.size() == 0) chk_ok("dv_unexpected", 1'b0, int'(value_X));
                else                   chk("value_x", value_X, exp_q.pop_front());
                held = value_X;
            end else if (value_X !== held) begin
                stable_bad++;
            end

            if (!CS_n && cs_p) begin
                if (frame_no > 0) chk_ok("cs_high_gap", (cyc - rise_cyc) >= 8, cyc - rise_cyc);
                is_rd = (frame_no > 0);
                if (is_rd) begin
                    if (have_rd_fall) chk("read_period", cyc - last_rd_fall, 2000);
                    last_rd_fall = cyc;
                    have_rd_fall = 1'b1;
                    miso_word = {16'h0000, r_xl[r_idx % 16], r_xh[r_idx % 16]};
                    exp_q.push_back(expect_x(r_xl[r_idx % 16], r_xh[r_idx % 16]));
                    r_idx++;
                end else begin
                    miso_word = '0;
                end
                in_frame = 1'b1; rises = 0; bitk = 0; mosi_sr = '0; spacing_bad = 1'b0;
                fall_cyc = cyc;
                miso = miso_word[31];
            end

            if (in_frame && SCLK && !sclk_p) begin
                if (rises == 0) first_rise = cyc;
                else if (cyc - last_rise != 8) spacing_bad = 1'b1;
                last_rise = cyc;
                mosi_sr = {mosi_sr[30:0], MOSI};
                rises++;
            end

            if (in_frame && !SCLK && sclk_p) begin
                last_fall = cyc;
                bitk++;
                miso = (bitk < 32) ? miso_word[31 - bitk] : 1'b0;
            end

            if (CS_n && !cs_p && in_frame) begin
                chk("sclk_rises", rises, is_rd ? 32 : 24);
                chk("mosi_bytes", mosi_sr, is_rd ? 32'h0B0E0000 : 32'h000A2D02);
                chk("cs_lead", first_rise - fall_cyc, 4);
                chk("cs_tail", cyc - last_fall, 4);
                chk_ok("sclk_spacing", !spacing_bad, 0);
                in_frame = 1'b0;
                frame_no++;
                rise_cyc = cyc;
                miso = 1'b0;
            end

            cs_p = CS_n; sclk_p = SCLK; mosi_p = MOSI;
        end
    end

    bit fcs_p;
    int f_frames, f_dv_since, f_rise;
    int f_dv_total = 0;

    // Back-to-back monitor: slave answers all ones, so every sample is -1.
    always @(negedge clk) begin
        if (!rst_n) begin
            fcs_p = 1'b1; f_frames = 0; f_dv_since = 0;
        end else begin
            if (cs_f && (sclk_f || mosi_f)) proto_bad++;
            if (dv_f) begin
                f_dv_total++;
                f_dv_since++;
                chk("fast_value", value_f, 15'h7FFF);
            end
            if (!cs_f && fcs_p) begin
                if (f_frames > 0) chk_ok("fast_gap_min", (cyc - f_rise) >= 8, cyc - f_rise);
                if (f_frames >= 2) begin
                    chk_ok("fast_gap_max", (cyc - f_rise) <= 12, cyc - f_rise);
                    chk("fast_dv_per_frame", f_dv_since, 1);
                end
                f_dv_since = 0;
                f_frames++;
            end
            if (cs_f && !fcs_p) f_rise = cyc;
            fcs_p = cs_f;
        end
    end

    task automatic wait_dv(input int target, input int budget);
        int n;
        n = 0;
        while (dv_cnt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (dv_cnt < target) chk_ok("timeout_dv", 1'b0, dv_cnt);
    endtask

    task automatic wait_cs_low(input int budget);
        int n;
        n = 0;
        while (CS_n !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (CS_n !== 1'b0) chk_ok("timeout_cs", 1'b0, n);
    endtask

    initial begin
        rst_n  = 1'b0;
        miso_f = 1'b1;
        for (int i = 0; i < 16; i++) begin
            r_xl[i] = 8'($urandom);
            r_xh[i] = 8'($urandom);
        end
        r_xl[0] = 8'h66; r_xh[0] = 8'h00;
        r_xl[1] = 8'hBA; r_xh[1] = 8'hFF;
        r_xl[2] = 8'hFF; r_xh[2] = 8'h07;
        r_xl[3] = 8'h00; r_xh[3] = 8'hF8;
        r_xl[5] = r_xl[5] | 8'h01;

        #100;
        chk("reset_cs_n", CS_n, 1);
        chk("reset_sclk", SCLK, 0);
        chk("reset_mosi", MOSI, 0);
        chk("reset_value", value_X, 0);
        chk("reset_dv", data_valid, 0);

        @(negedge clk);
        rst_n = 1'b1;
        wait_dv(6, 15000);
        wait_cs_low(3000);
        repeat (100) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_cs_n", CS_n, 1);
        chk("abort_sclk", SCLK, 0);
        chk("abort_mosi", MOSI, 0);
        chk("abort_value", value_X, 0);
        chk("abort_dv", data_valid, 0);

        #50;
        @(negedge clk);
        rst_n = 1'b1;
        wait_dv(dv_cnt + 2, 6000);
        repeat (20) @(negedge clk);

        chk("protocol_violations", proto_bad, 0);
        chk("value_stable", stable_bad, 0);
        chk("pending_expected", exp_q.size(), 0);
        chk_ok("fast_dv_count", f_dv_total >= 10, f_dv_total);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/adxl362_x_reader.md
ADXL362_X_READER -- requirements
Module: adxl362_x_reader

Interface
REQ-001 SHALL have parameter CLK_DIV, default 50, clk cycles per SCLK half-period (1 MHz SCLK at 100 MHz).
REQ-002 SHALL have parameter SAMPLE_PERIOD, default 10_000_000, clk cycles between X-axis read starts.
REQ-003 SHALL have parameter STARTUP_WAIT, default 1_000_000, clk cycles from reset release to first SPI access.
REQ-004 clk  input  1  system clock; single clock domain.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 SCLK  output  1  SPI clock, mode 0 (CPOL=0, CPHA=0).
REQ-007 MOSI  output  1  SPI data to ADXL362, MSB first.
REQ-008 MISO  input  1  SPI data from ADXL362, sampled on SCLK rising edge.
REQ-009 CS_n  output  1  active-low chip select.
REQ-010 value_X  output  15  latest X-axis sample, 12-bit two's complement sign-extended to 15 bits; feeds the UART controller.
REQ-011 data_valid  output  1  one-clk pulse when value_X updates.

Function
REQ-012 States: STARTUP, INIT_XFER, INIT_GAP, WAIT_SAMPLE, READ_XFER, UPDATE.
REQ-013 STARTUP counts STARTUP_WAIT cycles, then enters INIT_XFER.
REQ-014 INIT_XFER: one CS_n-low frame of 3 bytes 0x0A, 0x2D, 0x02 (write POWER_CTL = measurement mode), then INIT_GAP.
REQ-015 INIT_GAP: CS_n high for at least 2*CLK_DIV cycles, then WAIT_SAMPLE with sample timer cleared.
REQ-016 WAIT_SAMPLE: free-running timer; on reaching SAMPLE_PERIOD-1 it wraps to 0 and FSM enters READ_XFER; read starts are exactly SAMPLE_PERIOD cycles apart.
REQ-017 READ_XFER: one CS_n-low frame of 4 bytes: 0x0B, 0x0E, then two dummy 0x00 bytes while capturing XDATA_L (byte 3) and XDATA_H (byte 4).
REQ-018 Frame timing: CS_n falls CLK_DIV cycles before first SCLK rise; CS_n rises CLK_DIV cycles after last SCLK fall; no SCLK gap between bytes in a frame.
REQ-019 MOSI SHALL change only while SCLK low (on falling edge, or at CS_n fall for bit 7 of byte 1); MOSI = 0 when CS_n high.
REQ-020 UPDATE (one cycle): value_X <= {XDATA_H[3], XDATA_H[3], XDATA_H[3], XDATA_H[3:0], XDATA_L[7:0]}; data_valid = 1; next state WAIT_SAMPLE.
REQ-021 XDATA_H[7:4] SHALL be ignored; value_X SHALL hold its value between updates.
REQ-022 If a read frame (incl. CS_n high time) exceeds SAMPLE_PERIOD, the next read SHALL start immediately after UPDATE; no read is queued twice.
REQ-023 SCLK idles low; SCLK toggles only while CS_n low.

Reset
REQ-024 On reset low: state STARTUP, all counters 0, SCLK=0, MOSI=0, CS_n=1, value_X=0, data_valid=0, immediately (asynchronous).
REQ-025 Reset asserted mid-frame SHALL abort the frame (CS_n high at once); after release the full STARTUP and INIT sequence repeats.

Structure
REQ-026 Shared package adxl362_pkg: opcodes WRITE=0x0A, READ=0x0B; addresses POWER_CTL=0x2D, XDATA_L=0x0E; MEAS_MODE=0x02; FSM state encoding.
REQ-027 One sub-module spi_byte_shifter: loads tx byte, generates 8 SCLK periods from CLK_DIV, shifts MOSI/samples MISO, pulses done with rx byte; top FSM sequences bytes and CS_n.

Verification
REQ-028 Reset: hold reset low 100 ns -> CS_n=1, SCLK=0, MOSI=0, value_X=0, data_valid=0; assert mid-READ_XFER -> CS_n=1 same cycle, value_X=0.
REQ-029 Init (STARTUP_WAIT=100, CLK_DIV=4) -> one frame decoded by SPI slave model as 0x0A, 0x2D, 0x02; 24 SCLK rises; CS_n high >= 8 cycles afterward.
REQ-030 Slave returns XDATA_L=0x66, XDATA_H=0x00 -> MOSI bytes 0x0B, 0x0E, 0x00, 0x00; value_X = 15'd102; one data_valid pulse.
REQ-031 Slave returns XDATA_L=0xBA, XDATA_H=0xFF -> value_X = 15'h7FBA (-70); XDATA_H=0x07, XDATA_L=0xFF -> 15'd2047; XDATA_H=0xF8, XDATA_L=0x00 -> 15'h7800 (-2048).
REQ-032 SAMPLE_PERIOD=2000 -> successive CS_n falling edges of read frames exactly 2000 clk apart over 5 reads; value_X stable between data_valid pulses.
REQ-033 SAMPLE_PERIOD=50, CLK_DIV=4 (frame longer than period) -> reads back-to-back with CS_n high >= 8 cycles between frames; exactly one data_valid per frame.
